// File: rtl/alu_pin_host.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_pin_host
// Host-side sequencer for a pin-level 3-bit ALU. Takes one request, drives
// {op, b, a} onto the ALU input pins, waits WAIT_CYCLES edges for the ALU to
// settle, captures {op echo, result} from the ALU output pins and offers it
// as a response.
//
// Optional feature (macro ALU_PIN_HOST_CHECK_EN): an on-line result checker
// that recomputes the expected ALU result and flags mismatches through
// chk_fail (sticky) and chk_count (saturating mismatch counter).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   ena        clock enable; when low every register holds
//   req_valid  request valid           req_ready  request ready (IDLE & ena)
//   req_op     ALU operation (00 add, 01 sub, 10 mul, 11 div)
//   req_a      operand a               req_b      operand b
//   pin_out    ALU input pins {op, b, a}
//   pin_in     ALU output pins {op echo, result[5:0]}
//   rsp_valid  response valid          rsp_ready  response ready
//   rsp_result captured result         rsp_op     operation of this response
//   rsp_err    op echo did not match the issued op
//   chk_fail   (checker only) sticky mismatch flag
//   chk_count  (checker only) saturating mismatch count
// ---------------------------------------------------------------------------
module alu_pin_host #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [2:0] req_a,
    input  logic [2:0] req_b,
    output logic [7:0] pin_out,
    input  logic [7:0] pin_in,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [5:0] rsp_result,
    output logic [1:0] rsp_op,
    output logic       rsp_err
`ifdef ALU_PIN_HOST_CHECK_EN
    ,
    output logic       chk_fail,
    output logic [7:0] chk_count
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Counter is loaded so that WAIT lasts WAIT_CYCLES-1 edges; together with
    // the DRIVE edge this places WAIT_CYCLES edges between drive and sample.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic [1:0] op_r;
    logic [2:0] a_r;
    logic [2:0] b_r;

    // Ready is only offered while idle and enabled, so accept and response
    // handshakes can never coincide.
    assign req_ready = (state_r == IDLE) && ena;

    // State register; ena low freezes the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else if (ena) begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_s = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                state_s = WAIT;
            end
            WAIT: begin
                // Leaving on the edge where the counter steps 1 -> 0.
                if (cnt_r <= 4'd1) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = WAIT;
                end
            end
            CAPTURE: begin
                state_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath: request latch, pin drive, wait counter and response registers.
    // pin_out is deliberately left untouched after RESP so the ALU inputs stay
    // stable until the next request is driven.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r       <= 2'd0;
            a_r        <= 3'd0;
            b_r        <= 3'd0;
            cnt_r      <= 4'd0;
            pin_out    <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_result <= 6'd0;
            rsp_op     <= 2'd0;
            rsp_err    <= 1'b0;
        end else if (ena) begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        op_r <= req_op;
                        a_r  <= req_a;
                        b_r  <= req_b;
                    end
                end
                DRIVE: begin
                    pin_out <= {op_r, b_r, a_r};
                    cnt_r   <= WAIT_LOAD;
                end
                WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                CAPTURE: begin
                    rsp_result <= pin_in[5:0];
                    rsp_op     <= op_r;
                    rsp_err    <= (pin_in[7:6] != op_r);
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_PIN_HOST_CHECK_EN
    // Expected ALU result: low 6 bits of the 8-bit result on zero-extended
    // operands. Division by zero returns 0 here; callers exclude that case.
    function automatic logic [5:0] expect_result(input logic [1:0] op,
                                                 input logic [2:0] a,
                                                 input logic [2:0] b);
        logic [7:0] ae;
        logic [7:0] be;
        logic [7:0] r;
        ae = {5'd0, a};
        be = {5'd0, b};
        case (op)
            2'b00:   r = ae + be;
            2'b01:   r = ae - be;
            2'b10:   r = ae * be;
            2'b11:   r = (be == 8'd0) ? 8'd0 : (ae / be);
            default: r = 8'd0;
        endcase
        return r[5:0];
    endfunction

    logic mismatch_s;

    // Mismatch qualifier for the captured sample; divide-by-zero is unchecked.
    always_comb begin
        mismatch_s = 1'b0;
        if ((op_r == 2'b11) && (b_r == 3'd0)) begin
            mismatch_s = 1'b0;
        end else begin
            mismatch_s = (pin_in[5:0] != expect_result(op_r, a_r, b_r));
        end
    end

    // Sticky fail flag and saturating mismatch counter, updated at CAPTURE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_fail  <= 1'b0;
            chk_count <= 8'd0;
        end else if (ena && (state_r == CAPTURE) && mismatch_s) begin
            chk_fail <= 1'b1;
            if (chk_count != 8'hFF) begin
                chk_count <= chk_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_pin_host.sv
`timescale 1ns/1ps
// Self-checking bench for alu_pin_host: directed cases plus randomized
// transactions checked against an arithmetic reference of the ALU and of the
// host's handshake/latency behaviour.
module tb_alu_pin_host;

    localparam int WAIT_CYCLES = 2;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_a;
    logic [2:0] req_b;
    logic [7:0] pin_out;
    logic [7:0] pin_in;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_result;
    logic [1:0] rsp_op;
    logic       rsp_err;
`ifdef ALU_PIN_HOST_CHECK_EN
    logic       chk_fail;
    logic [7:0] chk_count;
`endif

    int         n_checks;
    int         n_fail;
    int         exp_cnt;
    bit         exp_fail;
    logic [7:0] last_pin;
    logic       force_en;
    logic [7:0] force_val;

    alu_pin_host #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .pin_out   (pin_out),
        .pin_in    (pin_in),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_op    (rsp_op),
        .rsp_err   (rsp_err)
`ifdef ALU_PIN_HOST_CHECK_EN
        ,
        .chk_fail  (chk_fail),
        .chk_count (chk_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: low 6 bits of the 8-bit result of the operation.
    function automatic int ref_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b + 256;
            2:       r = a * b;
            3:       r = (b == 0) ? 63 : a / b;
            default: r = 0;
        endcase
        return (r % 256) % 64;
    endfunction

    // Ideal ALU pins: echo the op and return the reference result.
    function automatic logic [7:0] pin_model(input logic [7:0] p);
        int r;
        r = ref_alu(int'(p[7:6]), int'(p[2:0]), int'(p[5:3]));
        return {p[7:6], r[5:0]};
    endfunction

    assign pin_in = force_en ? force_val : pin_model(pin_out);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Count edges from the current negedge until rsp_valid is seen high.
    task automatic wait_rsp(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic check_chk();
`ifdef ALU_PIN_HOST_CHECK_EN
        check_eq("chk_fail", chk_fail, exp_fail);
        check_eq("chk_count", chk_count, exp_cnt);
`endif
    endtask

    // One full transaction; hold = cycles rsp_ready stays low after rsp_valid.
    task automatic run_txn(input int op, input int a, input int b,
                           input bit use_force, input logic [7:0] fval, input int hold);
        int         edges;
        logic [7:0] exp_pin;
        logic [7:0] cap;
        int         ref_r;
        exp_pin   = {op[1:0], b[2:0], a[2:0]};
        ref_r     = ref_alu(op, a, b);
        cap       = use_force ? fval : {op[1:0], ref_r[5:0]};
        force_en  = use_force;
        force_val = fval;
        if (!((op == 3) && (b == 0)) && (cap[5:0] != ref_r[5:0])) begin
            exp_fail = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
        end
        @(negedge clk);
        check_eq("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op[1:0];
        req_a     = a[2:0];
        req_b     = b[2:0];
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_a     = 3'($urandom);
        req_b     = 3'($urandom);
        wait_rsp(edges);
        if (!rsp_valid) begin
            check_eq("rsp_timeout", 1'b0, 1'b1);
            return;
        end
        // Edges counted inclusively from the accept edge to the first edge
        // that sees rsp_valid high.
        check_eq("latency", edges + 2, WAIT_CYCLES + 3);
        check_eq("pin_out", pin_out, exp_pin);
        check_eq("rsp_result", rsp_result, cap[5:0]);
        check_eq("rsp_op", rsp_op, op[1:0]);
        check_eq("rsp_err", rsp_err, (cap[7:6] != op[1:0]));
        check_chk();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", rsp_valid, 1'b1);
            check_eq("hold_result", rsp_result, cap[5:0]);
            check_eq("hold_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_done", rsp_valid, 1'b0);
        check_eq("idle_after_rsp", req_ready, 1'b1);
        check_eq("pin_keep", pin_out, exp_pin);
        last_pin = exp_pin;
    endtask

    // ena low must freeze the FSM mid-operation and while a response waits.
    task automatic ena_hold_test();
        int edges;
        force_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 3'd1;
        req_b     = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        ena       = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("ena_pin_hold", pin_out, last_pin);
        check_eq("ena_rdy_low", req_ready, 1'b0);
        check_eq("ena_no_rsp", rsp_valid, 1'b0);
        ena = 1'b1;
        wait_rsp(edges);
        check_eq("ena_resume_lat", edges, WAIT_CYCLES + 1);
        check_eq("ena_result", rsp_result, 6'd3);
        ena       = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("ena_rsp_hold", rsp_valid, 1'b1);
        check_eq("ena_pin", pin_out, 8'h11);
        ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("ena_rsp_done", rsp_valid, 1'b0);
        check_eq("ena_idle_rdy", req_ready, 1'b1);
        ena = 1'b0;
        #1;
        check_eq("ena_idle_rdy_low", req_ready, 1'b0);
        ena      = 1'b1;
        last_pin = 8'h11;
    endtask

    // Reset during WAIT abandons the operation.
    task automatic reset_test();
        bit seen;
        force_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_a     = 3'd3;
        req_b     = 3'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_pin", pin_out, 8'h00);
        check_eq("rst_valid", rsp_valid, 1'b0);
        check_eq("rst_result", rsp_result, 6'd0);
        exp_cnt  = 0;
        exp_fail = 1'b0;
        last_pin = 8'h00;
        check_chk();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_rel_ready", req_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("rst_no_rsp", seen, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int a;
        int b;
        bit f;
        logic [7:0] fv;
        int hold;
        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = 0;
        exp_fail  = 1'b0;
        last_pin  = 8'h00;
        rst       = 1'b0;
        ena       = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 3'd0;
        req_b     = 3'd0;
        rsp_ready = 1'b0;
        force_en  = 1'b0;
        force_val = 8'h00;
        #2;
        check_eq("reset_pin", pin_out, 8'h00);
        check_eq("reset_valid", rsp_valid, 1'b0);
        check_eq("reset_result", rsp_result, 6'd0);
        check_eq("reset_op", rsp_op, 2'd0);
        check_eq("reset_err", rsp_err, 1'b0);
        check_chk();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;

        run_txn(0, 5, 6, 1'b0, 8'h00, 0);
        run_txn(1, 2, 5, 1'b1, 8'h7D, 0);
        run_txn(2, 7, 7, 1'b1, 8'h80, 0);
        run_txn(3, 7, 0, 1'b1, 8'h3F, 0);
        run_txn(0, 3, 4, 1'b0, 8'h00, 6);
        ena_hold_test();
        reset_test();

        for (int t = 0; t < 40; t++) begin
            op   = $urandom_range(3, 0);
            a    = $urandom_range(7, 0);
            b    = $urandom_range(7, 0);
            f    = ($urandom_range(3, 0) == 0);
            fv   = 8'($urandom);
            hold = $urandom_range(3, 0);
            run_txn(op, a, b, f, fv, hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
